fir_coeff_loader: RTL and testbench

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_coeff_loader.sv | 120 ++++++++++++
 tb/tb_fir_coeff_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR constants and loader state encoding.
// Used by fir_15 and fir_coeff_loader.
package fir_pkg;

   localparam int NUM_COEFFS  = 15;
   localparam int COEFF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } fir_state_e;

endpackage

// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader: fills a shadow set, then commits it
// atomically onto the packed coeffs bus feeding the FIR.
// Ports:
//   clk, rst            clock, async active-high reset
//   load_start          begin (or restart) a coefficient load
//   coeff_in/_valid     serial coefficient stream, handshake in
//   coeff_in_ready      high while loading (state decode only)
//   coeffs              packed taps, index 0 at LSBs
//   coeffs_valid        at least one full set committed
//   commit_pulse        one cycle, coeffs just took a new set
//   busy                load in progress
//   load_error          one cycle, a load was restarted
module fir_coeff_loader #(
   parameter int NUM_COEFFS  = fir_pkg::NUM_COEFFS,
   parameter int COEFF_WIDTH = fir_pkg::COEFF_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              load_start,
   input  logic [COEFF_WIDTH-1:0]            coeff_in,
   input  logic                              coeff_in_valid,
   output logic                              coeff_in_ready,
   output logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs,
   output logic                              coeffs_valid,
   output logic                              commit_pulse,
   output logic                              busy,
   output logic                              load_error
);

   import fir_pkg::*;

   localparam int IDX_W = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

   fir_state_e state_q, state_d;

   logic [IDX_W-1:0] idx_q, idx_d;

   logic [COEFF_WIDTH-1:0] shadow_q [NUM_COEFFS];
   logic [COEFF_WIDTH-1:0] shadow_d [NUM_COEFFS];

   logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs_q, coeffs_d;

   logic coeffs_valid_q, coeffs_valid_d;
   logic load_error_q, load_error_d;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      shadow_d       = shadow_q;
      coeffs_d       = coeffs_q;
      coeffs_valid_d = coeffs_valid_q;
      load_error_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d = ST_LOAD;
               idx_d   = '0;
            end
         end
         ST_LOAD: begin
            // Restart wins over a same-cycle transfer.
            if (load_start) begin
               idx_d        = '0;
               load_error_d = 1'b1;
            end else if (coeff_in_valid) begin
               shadow_d[idx_q] = coeff_in;
               if (idx_q == LAST_IDX) begin
                  // Commit on this edge so the bus updates
                  // right after the final transfer.
                  state_d        = ST_COMMIT;
                  idx_d          = '0;
                  coeffs_valid_d = 1'b1;
                  for (int i = 0; i < NUM_COEFFS; i++) begin
                     coeffs_d[i*COEFF_WIDTH +: COEFF_WIDTH] =
                        shadow_d[i];
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         coeffs_q       <= '0;
         coeffs_valid_q <= 1'b0;
         load_error_q   <= 1'b0;
         for (int i = 0; i < NUM_COEFFS; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         coeffs_q       <= coeffs_d;
         coeffs_valid_q <= coeffs_valid_d;
         load_error_q   <= load_error_d;
         shadow_q       <= shadow_d;
      end
   end

   assign coeff_in_ready = (state_q == ST_LOAD);
   assign busy           = (state_q == ST_LOAD);
   assign commit_pulse   = (state_q == ST_COMMIT);
   assign coeffs         = coeffs_q;
   assign coeffs_valid   = coeffs_valid_q;
   assign load_error     = load_error_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader.
// Table vectors, hand corner cases and random traffic vs a model.
module tb_fir_coeff_loader;

   localparam int N = 15;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           load_start = 1'b0;
   logic [W-1:0]   coeff_in = '0;
   logic           coeff_in_valid = 1'b0;
   logic           coeff_in_ready;
   logic [N*W-1:0] coeffs;
   logic           coeffs_valid;
   logic           commit_pulse;
   logic           busy;
   logic           load_error;

   fir_coeff_loader #(
      .NUM_COEFFS  (N),
      .COEFF_WIDTH (W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .load_start     (load_start),
      .coeff_in       (coeff_in),
      .coeff_in_valid (coeff_in_valid),
      .coeff_in_ready (coeff_in_ready),
      .coeffs         (coeffs),
      .coeffs_valid   (coeffs_valid),
      .commit_pulse   (commit_pulse),
      .busy           (busy),
      .load_error     (load_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int err_seen = 0;
   int commit_seen = 0;

   // Reference model: a list of received values, committed set.
   bit           m_loading;
   bit           m_commit;
   bit           m_err;
   bit           m_valid;
   logic [W-1:0] m_coeffs [N];
   logic [W-1:0] m_buf [$];

   typedef struct {
      logic [W-1:0] first;
      logic [W-1:0] stp;
      int           gap;
      logic [W-1:0] exp0;
      logic [W-1:0] exp14;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_loading = 0;
      m_commit  = 0;
      m_err     = 0;
      m_valid   = 0;
      m_buf.delete();
      for (int i = 0; i < N; i++) m_coeffs[i] = '0;
   endtask

   task automatic model_update(input logic ls, input logic v,
                               input logic [W-1:0] d);
      bit new_commit;
      bit new_err;
      new_commit = 0;
      new_err    = 0;
      if (m_commit) begin
         // commit cycle: request ignored, back to idle
      end else if (!m_loading) begin
         if (ls) begin
            m_loading = 1;
            m_buf.delete();
         end
      end else if (ls) begin
         m_buf.delete();
         new_err = 1;
      end else if (v) begin
         m_buf.push_back(d);
         if (m_buf.size() == N) begin
            for (int i = 0; i < N; i++) m_coeffs[i] = m_buf[i];
            m_valid    = 1;
            new_commit = 1;
            m_loading  = 0;
            m_buf.delete();
         end
      end
      m_commit = new_commit;
      m_err    = new_err;
   endtask

   function automatic logic [N*W-1:0] model_bus();
      logic [N*W-1:0] b;
      for (int i = 0; i < N; i++) b[i*W +: W] = m_coeffs[i];
      return b;
   endfunction

   task automatic check_all();
      chk("coeffs", 128'(coeffs), 128'(model_bus()));
      chk("coeffs_valid", 128'(coeffs_valid), 128'(m_valid));
      chk("commit_pulse", 128'(commit_pulse), 128'(m_commit));
      chk("coeff_in_ready", 128'(coeff_in_ready), 128'(m_loading));
      chk("busy", 128'(busy), 128'(m_loading));
      chk("load_error", 128'(load_error), 128'(m_err));
   endtask

   // Drive, clock, update model, sample 1 time unit after the edge.
   task automatic step(input logic ls, input logic v,
                       input logic [W-1:0] d);
      load_start     = ls;
      coeff_in_valid = v;
      coeff_in       = d;
      @(posedge clk);
      if (rst) model_reset();
      else model_update(ls, v, d);
      #1;
      if (load_error) err_seen++;
      if (commit_pulse) commit_seen++;
      check_all();
   endtask

   task automatic gaps(input int max_gap);
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) step(1'b0, 1'b0, W'($urandom));
   endtask

   initial begin
      logic [W-1:0] val;

      vecs[0] = '{8'h01, 8'h01, 0, 8'h01, 8'h0F};
      vecs[1] = '{8'hF8, 8'h01, 3, 8'hF8, 8'h06};
      vecs[2] = '{8'h03, 8'h00, 0, 8'h03, 8'h03};
      vecs[3] = '{8'h80, 8'h01, 2, 8'h80, 8'h8E};
      vecs[4] = '{8'h7F, 8'hFF, 1, 8'h7F, 8'h71};

      model_reset();
      #2;
      chk("rst_coeffs", 128'(coeffs), 128'(0));
      chk("rst_ready", 128'(coeff_in_ready), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle holds without load_start, even with valid data.
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'hA5);

      // Table-driven loads.
      for (int t = 0; t < 5; t++) begin
         step(1'b1, 1'b0, '0);
         for (int i = 0; i < N; i++) begin
            gaps(vecs[t].gap);
            val = vecs[t].first + vecs[t].stp * W'(i);
            step(1'b0, 1'b1, val);
         end
         chk("tbl_commit", 128'(commit_pulse), 128'(1));
         chk("tbl_tap0", 128'(coeffs[W-1:0]), 128'(vecs[t].exp0));
         chk("tbl_tap14", 128'(coeffs[N*W-1 -: W]),
             128'(vecs[t].exp14));
         step(1'b0, 1'b0, '0);
      end

      // Restart mid-load: old set stays until the new commit.
      err_seen = 0;
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, W'(8'h50 + i));
      step(1'b1, 1'b1, 8'h77);
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, 8'h03);
      for (int i = 0; i < N; i++)
         chk("abort_tap", 128'(coeffs[i*W +: W]), 128'(8'h03));
      // load_start during the commit cycle is ignored.
      step(1'b1, 1'b0, '0);
      chk("commit_ls_ready", 128'(coeff_in_ready), 128'(0));
      step(1'b0, 1'b1, 8'h11);
      chk("abort_err_count", 128'(err_seen), 128'(1));

      // Async reset mid-cycle after 10 transfers.
      commit_seen = 0;
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, W'(8'h40 + i));
      #2;
      rst = 1'b1;
      #1;
      chk("arst_coeffs", 128'(coeffs), 128'(0));
      chk("arst_valid", 128'(coeffs_valid), 128'(0));
      chk("arst_ready", 128'(coeff_in_ready), 128'(0));
      chk("arst_busy", 128'(busy), 128'(0));
      model_reset();
      step(1'b0, 1'b1, 8'h99);
      step(1'b0, 1'b1, 8'h99);
      rst = 1'b0;
      chk("arst_no_commit", 128'(commit_seen), 128'(0));
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, W'(8'd20 + i));
      chk("post_rst_tap3", 128'(coeffs[3*W +: W]), 128'(8'd23));
      step(1'b0, 1'b0, '0);

      // Random traffic with aborts, gaps and random data.
      for (int k = 0; k < 1500; k++) begin
         step(($urandom_range(29, 0) == 0),
              ($urandom_range(2, 0) != 0),
              W'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
